// File: rtl/reflet_vga_layer_blender.sv
`default_nettype none
// ============================================================================
// Module   : reflet_vga_layer_blender
// Brief    : Fixed-latency VGA layer compositor. Stage 0 registers the syncs,
//            the background and every layer's colour and alpha. Each later
//            stage k blends layer k-1 over the result of stage k-1. Layer 0
//            is the lowest layer and layer layers-1 is the topmost.
//            Latency is layers+1 cycles. One pixel is accepted every cycle.
// Options  : REFLET_VGA_BLEND_ALPHA_EN
//              - defined:   weighted alpha blending.
//              - undefined: binary alpha, where any non-zero alpha selects
//                           the layer colour.
// Revision : 1.0 - initial release
// ============================================================================
module reflet_vga_layer_blender #(
   parameter int color_depth = 2,
   parameter int layers      = 2,
   parameter int alpha_depth = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            pix_valid_in,
   input  logic                            h_sync_in,
   input  logic                            v_sync_in,
   input  logic [color_depth-1:0]          R_bg,
   input  logic [color_depth-1:0]          G_bg,
   input  logic [color_depth-1:0]          B_bg,
   input  logic [layers*color_depth-1:0]   R_layers,
   input  logic [layers*color_depth-1:0]   G_layers,
   input  logic [layers*color_depth-1:0]   B_layers,
   input  logic [layers*alpha_depth-1:0]   a_layers,
   output logic [color_depth-1:0]          R_out,
   output logic [color_depth-1:0]          G_out,
   output logic [color_depth-1:0]          B_out,
   output logic                            h_sync,
   output logic                            v_sync,
   output logic                            pix_valid_out
);

`ifdef REFLET_VGA_BLEND_ALPHA_EN
   // Full-scale weight, 2^alpha_depth. The all-ones alpha code maps onto
   // this weight so that an all-ones alpha gives a fully opaque layer.
   localparam logic [alpha_depth:0] c_full = {1'b1, {alpha_depth{1'b0}}};
`endif

   // Accumulated colour and timing for each stage. Index 0 holds the
   // sampled background. Index layers holds the finished pixel.
   logic [color_depth-1:0]        r_red   [0:layers];
   logic [color_depth-1:0]        r_grn   [0:layers];
   logic [color_depth-1:0]        r_blu   [0:layers];
   logic                          r_valid [0:layers];
   logic                          r_hs    [0:layers];
   logic                          r_vs    [0:layers];

   // Layer data sampled in stage 0 and carried along with its own pixel.
   // Later input changes therefore cannot affect a pixel in flight.
   logic [layers*color_depth-1:0] r_lay_r [0:layers-1];
   logic [layers*color_depth-1:0] r_lay_g [0:layers-1];
   logic [layers*color_depth-1:0] r_lay_b [0:layers-1];
   logic [layers*alpha_depth-1:0] r_lay_a [0:layers-1];

   // Blend result presented to each stage register.
   logic [color_depth-1:0]        w_red   [1:layers];
   logic [color_depth-1:0]        w_grn   [1:layers];
   logic [color_depth-1:0]        w_blu   [1:layers];

   // Blend one channel of a foreground colour over a background colour.
   function automatic logic [color_depth-1:0] blend_ch(
      input logic [color_depth-1:0] fg,
      input logic [color_depth-1:0] bg,
      input logic [alpha_depth-1:0] a
   );
`ifdef REFLET_VGA_BLEND_ALPHA_EN
      logic [alpha_depth:0]             w;
      logic [alpha_depth:0]             w_inv;
      logic [color_depth+alpha_depth:0] sum;
      w     = (a == '1) ? c_full : {1'b0, a};
      w_inv = c_full - w;
      // The sum is at most 2^alpha_depth * (2^color_depth - 1), so it
      // cannot overflow this width.
      sum   = ({{color_depth{1'b0}}, w}     * {{(alpha_depth+1){1'b0}}, fg})
            + ({{color_depth{1'b0}}, w_inv} * {{(alpha_depth+1){1'b0}}, bg});
      blend_ch = color_depth'(sum >> alpha_depth);
`else
      blend_ch = (a != '0) ? fg : bg;
`endif
   endfunction

   // Stage k composites layer k-1 over the colour produced by stage k-1.
   always_comb begin
      for (int k = 1; k <= layers; k++) begin
         w_red[k] = blend_ch(r_lay_r[k-1][(k-1)*color_depth +: color_depth], r_red[k-1],
                             r_lay_a[k-1][(k-1)*alpha_depth +: alpha_depth]);
         w_grn[k] = blend_ch(r_lay_g[k-1][(k-1)*color_depth +: color_depth], r_grn[k-1],
                             r_lay_a[k-1][(k-1)*alpha_depth +: alpha_depth]);
         w_blu[k] = blend_ch(r_lay_b[k-1][(k-1)*color_depth +: color_depth], r_blu[k-1],
                             r_lay_a[k-1][(k-1)*alpha_depth +: alpha_depth]);
      end
   end

   // Pipeline registers. Reset is asynchronous, discards every pixel in
   // flight, and leaves both syncs at their idle-high level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k <= layers; k++) begin
            r_red[k]   <= '0;
            r_grn[k]   <= '0;
            r_blu[k]   <= '0;
            r_valid[k] <= 1'b0;
            r_hs[k]    <= 1'b1;
            r_vs[k]    <= 1'b1;
         end
         for (int k = 0; k < layers; k++) begin
            r_lay_r[k] <= '0;
            r_lay_g[k] <= '0;
            r_lay_b[k] <= '0;
            r_lay_a[k] <= '0;
         end
      end else begin
         r_red[0]   <= R_bg;
         r_grn[0]   <= G_bg;
         r_blu[0]   <= B_bg;
         r_valid[0] <= pix_valid_in;
         r_hs[0]    <= h_sync_in;
         r_vs[0]    <= v_sync_in;
         r_lay_r[0] <= R_layers;
         r_lay_g[0] <= G_layers;
         r_lay_b[0] <= B_layers;
         r_lay_a[0] <= a_layers;
         for (int k = 1; k <= layers; k++) begin
            r_red[k]   <= w_red[k];
            r_grn[k]   <= w_grn[k];
            r_blu[k]   <= w_blu[k];
            r_valid[k] <= r_valid[k-1];
            r_hs[k]    <= r_hs[k-1];
            r_vs[k]    <= r_vs[k-1];
         end
         for (int k = 1; k < layers; k++) begin
            r_lay_r[k] <= r_lay_r[k-1];
            r_lay_g[k] <= r_lay_g[k-1];
            r_lay_b[k] <= r_lay_b[k-1];
            r_lay_a[k] <= r_lay_a[k-1];
         end
      end
   end

   // Colour is forced to black outside the visible area.
   assign R_out         = r_valid[layers] ? r_red[layers] : '0;
   assign G_out         = r_valid[layers] ? r_grn[layers] : '0;
   assign B_out         = r_valid[layers] ? r_blu[layers] : '0;
   assign h_sync        = r_hs[layers];
   assign v_sync        = r_vs[layers];
   assign pix_valid_out = r_valid[layers];

endmodule
`default_nettype wire

// File: tb/tb_reflet_vga_layer_blender.sv
`default_nettype none
// ============================================================================
// Module   : tb_reflet_vga_layer_blender
// Brief    : Self-checking bench for reflet_vga_layer_blender. A reference
//            model composites each applied pixel. The expected outputs are
//            queued and compared layers+1 cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reflet_vga_layer_blender;

   localparam int CD = 2;
   localparam int L  = 2;
   localparam int AD = 2;
   localparam int W  = 3 + 3*CD;

   // Output vector while reset holds the pipeline: valid 0, syncs 1, colour 0.
   localparam logic [W-1:0] RST_VEC = {1'b0, 1'b1, 1'b1, {(3*CD){1'b0}}};

   logic              clk = 1'b0;
   logic              reset;
   logic              pix_valid_in, h_sync_in, v_sync_in;
   logic [CD-1:0]     R_bg, G_bg, B_bg;
   logic [L*CD-1:0]   R_layers, G_layers, B_layers;
   logic [L*AD-1:0]   a_layers;
   logic [CD-1:0]     R_out, G_out, B_out;
   logic              h_sync, v_sync, pix_valid_out;

   int                checks = 0;
   int                errors = 0;
   logic [W-1:0]      exp_q[$];

   reflet_vga_layer_blender #(
      .color_depth(CD),
      .layers     (L),
      .alpha_depth(AD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pix_valid_in (pix_valid_in),
      .h_sync_in    (h_sync_in),
      .v_sync_in    (v_sync_in),
      .R_bg         (R_bg),
      .G_bg         (G_bg),
      .B_bg         (B_bg),
      .R_layers     (R_layers),
      .G_layers     (G_layers),
      .B_layers     (B_layers),
      .a_layers     (a_layers),
      .R_out        (R_out),
      .G_out        (G_out),
      .B_out        (B_out),
      .h_sync       (h_sync),
      .v_sync       (v_sync),
      .pix_valid_out(pix_valid_out)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] vec(input logic v, input logic hs, input logic vs,
                                        input logic [CD-1:0] r, input logic [CD-1:0] g,
                                        input logic [CD-1:0] b);
      return {v, hs, vs, r, g, b};
   endfunction

   // Reference model: paint the layers bottom to top over the background,
   // then black out the colour when the pixel is invalid.
   function automatic logic [W-1:0] model();
      int            bgc[3];
      int            lay[3];
      int            col, fg, a, full;
      logic [CD-1:0] oc[3];
`ifdef REFLET_VGA_BLEND_ALPHA_EN
      int            w;
`endif
      full   = 1 << AD;
      bgc[0] = int'(R_bg);
      bgc[1] = int'(G_bg);
      bgc[2] = int'(B_bg);
      lay[0] = int'(R_layers);
      lay[1] = int'(G_layers);
      lay[2] = int'(B_layers);
      for (int ch = 0; ch < 3; ch++) begin
         col = bgc[ch];
         for (int i = 0; i < L; i++) begin
            fg = (lay[ch] >> (i*CD)) % (1 << CD);
            a  = (int'(a_layers) >> (i*AD)) % full;
`ifdef REFLET_VGA_BLEND_ALPHA_EN
            w   = (a == full - 1) ? full : a;
            col = (w*fg + (full - w)*col) / full;
`else
            if (a != 0) col = fg;
`endif
         end
         if (!pix_valid_in) col = 0;
         oc[ch] = col[CD-1:0];
      end
      return {pix_valid_in, h_sync_in, v_sync_in, oc[0], oc[1], oc[2]};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] expv);
      logic [W-1:0] obs;
      obs = {pix_valid_out, h_sync, v_sync, R_out, G_out, B_out};
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Queue the expected output for the current inputs and advance one clock.
   // Then compare the output against the entry that is due.
   task automatic cycle();
      exp_q.push_back(model());
      @(posedge clk);
      #1;
      if (exp_q.size() > L) check("pipe", exp_q.pop_front());
   endtask

   task automatic rand_inputs();
      logic [31:0] r;
      r            = $urandom;
      R_layers     = r[0 +: L*CD];
      G_layers     = r[8 +: L*CD];
      B_layers     = r[16 +: L*CD];
      a_layers     = r[24 +: L*AD];
      r            = $urandom;
      R_bg         = r[0 +: CD];
      G_bg         = r[4 +: CD];
      B_bg         = r[8 +: CD];
      pix_valid_in = r[12] | r[13];
      h_sync_in    = r[14] | r[15] | r[16];
      v_sync_in    = r[17] | r[18];
   endtask

   // Hold the inputs for layers+1 cycles. Then the pixel they describe
   // must be on the outputs.
   task automatic hold_check(input string tag, input logic [W-1:0] expv);
      repeat (L + 1) cycle();
      check(tag, expv);
   endtask

   initial begin
      reset        = 1'b0;
      pix_valid_in = 1'b0;
      h_sync_in    = 1'b1;
      v_sync_in    = 1'b1;
      R_bg = '0; G_bg = '0; B_bg = '0;
      R_layers = '0; G_layers = '0; B_layers = '0; a_layers = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", RST_VEC);
      #2;
      reset = 1'b1;
      exp_q = {RST_VEC, RST_VEC};

      // Background only: the pixel appears exactly layers+1 cycles later.
      R_bg = 2'd0; G_bg = 2'd3; B_bg = 2'd0;
      pix_valid_in = 1'b1;
      cycle();
      cycle();
      check("latency_not_early", RST_VEC);
      cycle();
      check("bg_only", vec(1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0));

      // Half-weight red layer 0 over green background.
      R_layers = {2'd0, 2'd3}; G_layers = '0; B_layers = '0;
      a_layers = {2'd0, 2'd2};
`ifdef REFLET_VGA_BLEND_ALPHA_EN
      hold_check("half_alpha", vec(1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 2'd0));
`else
      hold_check("half_alpha", vec(1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 2'd0));
`endif

      // Opaque layers: the top layer wins, and a transparent top shows layer 0.
      R_layers = {2'd0, 2'd3}; B_layers = {2'd3, 2'd0};
      a_layers = {2'd3, 2'd3};
      hold_check("opaque_top", vec(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd3));
      a_layers = {2'd0, 2'd3};
      hold_check("opaque_l0", vec(1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 2'd0));

      // Smallest non-zero alpha, then zero alpha.
      B_layers = '0;
      a_layers = {2'd0, 2'd1};
`ifdef REFLET_VGA_BLEND_ALPHA_EN
      hold_check("alpha_one", vec(1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 2'd0));
`else
      hold_check("alpha_one", vec(1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 2'd0));
`endif
      a_layers = '0;
      hold_check("alpha_zero", vec(1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0));

      // Single-cycle pulses on valid and h_sync. The next inputs are
      // applied on adjacent cycles, so colour stays black while invalid.
      R_layers = 4'hF; G_layers = 4'hA; B_layers = 4'h5; a_layers = 4'hF;
      pix_valid_in = 1'b0;
      repeat (3) cycle();
      check("blank_colour", vec(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0));
      pix_valid_in = 1'b1; cycle();
      pix_valid_in = 1'b0; h_sync_in = 1'b0; cycle();
      h_sync_in = 1'b1; v_sync_in = 1'b0; cycle();
      h_sync_in = 1'b0; v_sync_in = 1'b1; pix_valid_in = 1'b1; cycle();
      h_sync_in = 1'b1; pix_valid_in = 1'b0; cycle();
      repeat (4) cycle();

      // Randomized stream.
      for (int n = 0; n < 300; n++) begin
         rand_inputs();
         cycle();
      end

      // Reset asserted between clock edges while the stream is running.
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", RST_VEC);
      exp_q.delete();
      repeat (2) begin
         rand_inputs();
         @(posedge clk);
         #1;
         check("reset_held", RST_VEC);
      end
      #2;
      reset = 1'b1;
      exp_q = {RST_VEC, RST_VEC};
      R_bg = 2'd1; G_bg = 2'd2; B_bg = 2'd3;
      a_layers = '0; pix_valid_in = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1;
      cycle();
      cycle();
      check("post_reset_not_early", RST_VEC);
      cycle();
      check("post_reset_first", vec(1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 2'd3));

      for (int n = 0; n < 100; n++) begin
         rand_inputs();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
